program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 8, instruction-memory word-address width (256 words).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_enable  in  1  level; high requests a program load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  holds the processor in reset while high.
- done  out  1  sticky flag: last load passed its checksum.
- error  out  1  sticky flag: last load failed its checksum.

Function
REQ-003 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both high.
REQ-004 The stream format SHALL be: one header byte H; then 4*(H+1) data bytes, big-endian per word (first byte goes to bits 31:24); then one checksum byte.
REQ-005 The word count N SHALL be H+1, so H=0 gives 1 word and H=255 gives 256 words.
REQ-006 The state machine SHALL have the states IDLE, HEADER, DATA, WRITE, CHECK, DONE and ERROR.
REQ-007 In IDLE, load_enable high SHALL move the machine to HEADER and clear done and error in the same edge.
REQ-008 In HEADER, an accepted byte SHALL latch H, clear imem_addr to 0, seed the running XOR with H, and move to DATA.
REQ-009 In DATA, each accepted byte SHALL shift into the word register and be XORed into the running checksum.
REQ-010 The fourth accepted byte of a word SHALL move the machine to WRITE on the next edge.
REQ-011 WRITE SHALL last exactly one cycle, with imem_we=1, imem_addr=current address and imem_wdata=the assembled word.
REQ-012 When leaving WRITE, imem_addr SHALL increment (wrapping modulo 2^ADDR_W), and the machine SHALL go to CHECK if N words have been written, otherwise to DATA.
REQ-013 In CHECK, the accepted byte SHALL be compared with the running XOR: a match sets done and moves to DONE; a mismatch sets error and moves to ERROR.
REQ-014 byte_ready SHALL be 1 only in HEADER, DATA and CHECK; it SHALL be 0 in WRITE, IDLE, DONE and ERROR.
REQ-015 imem_we SHALL be 0 in every state other than WRITE.
REQ-016 cpu_hold SHALL be 1 in HEADER, DATA, WRITE, CHECK and ERROR, and 0 in IDLE and DONE.
REQ-017 DONE and ERROR SHALL return to IDLE when load_enable is low; done and error keep their values until the next load start.
REQ-018 If load_enable goes low while in HEADER, DATA, WRITE or CHECK, the machine SHALL abort to IDLE on the next edge.
REQ-019 On such an abort, an in-flight WRITE strobe SHALL still complete in its cycle, done and error SHALL be unchanged, and any partial word SHALL be discarded.
REQ-020 When an abort and byte acceptance occur in the same cycle, the abort SHALL win and the byte SHALL be dropped.
REQ-021 Header-stage latency: byte accepted at edge k gives state DATA at k+1.
REQ-022 Write latency: the fourth byte accepted at edge k gives imem_we high for the cycle after k+1 (registered, one cycle).

Reset
REQ-023 While reset is high at an edge, the machine SHALL go to IDLE.
REQ-024 At that edge imem_addr, imem_wdata, the word register, the checksum, H and the word counter SHALL be cleared to 0.
REQ-025 At that edge done, error, imem_we, byte_ready and cpu_hold SHALL be 0.
REQ-026 Reset SHALL take priority over every other input, including mid-load; no imem_we is issued in the reset cycle or the cycle after it.

Verification
REQ-027 The bench SHALL cover the following directed scenarios.
- Single word: load_enable=1; stream 00, 12 34 56 78, then 00^12^34^56^78=08 -> one imem_we with addr 0, wdata 0x12345678; done=1; cpu_hold drops after CHECK.
- Two words, byte_valid held continuously: stream 01, 8 data bytes, correct XOR -> imem_we at addr 0 and addr 1; byte_ready=0 for exactly one cycle after each fourth byte.
- Bad checksum: single-word stream with final byte 09 -> state ERROR, error=1, done=0, cpu_hold=1 until load_enable=0.
- Abort: drop load_enable after 2 data bytes -> IDLE next edge, no imem_we, cpu_hold=0, done and error unchanged.
- Full memory: H=FF, 1024 bytes -> 256 writes at addresses 0..255; imem_addr wraps to 0 after the last write; done=1.
- Reset mid-DATA: assert reset for one cycle -> all outputs 0 the next cycle; a fresh load from address 0 then succeeds.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a byte stream (header, big-endian words, XOR checksum),
// writes the words into instruction memory, and holds the CPU in reset during a load.
module program_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_enable,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BYTE_W-1:0]   hdr;
  logic [BYTE_W-1:0]   csum;
  logic [BYTE_W-1:0]   word_cnt;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [WORD_W-1:0]   word;
  logic                accept;
  logic                byte_ready_d;
  logic                imem_we_d;
  logic                cpu_hold_d;

  // An abort (load_enable low) wins over a byte offered in the same cycle.
  assign accept = byte_valid & byte_ready & load_enable;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (load_enable) state_next = HEADER;
      HEADER: begin
        if (!load_enable) state_next = IDLE;
        else if (accept)  state_next = DATA;
      end
      DATA: begin
        if (!load_enable)                          state_next = IDLE;
        else if (accept && byte_cnt == BCNT_W'(3)) state_next = WRITE;
      end
      WRITE: begin
        if (!load_enable)        state_next = IDLE;
        else if (word_cnt == hdr) state_next = CHECK;
        else                      state_next = DATA;
      end
      CHECK: begin
        if (!load_enable) state_next = IDLE;
        else if (accept)  state_next = (byte_data == csum) ? DONE : ERROR;
      end
      DONE, ERROR: if (!load_enable) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    byte_ready_d = 1'b0;
    imem_we_d    = 1'b0;
    cpu_hold_d   = 1'b0;
    case (state_next)
      HEADER, DATA, CHECK: begin
        byte_ready_d = 1'b1;
        cpu_hold_d   = 1'b1;
      end
      WRITE: begin
        imem_we_d  = 1'b1;
        cpu_hold_d = 1'b1;
      end
      ERROR:   cpu_hold_d = 1'b1;
      default: ;
    endcase
  end

  // Registered state-decoded outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      byte_ready <= byte_ready_d;
      imem_we    <= imem_we_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

  // Datapath: header latch, word assembly, checksum, address/word counters, status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr        <= '0;
      csum       <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_enable) begin
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        HEADER: begin
          if (accept) begin
            hdr       <= byte_data;
            csum      <= byte_data;
            imem_addr <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word      <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            word     <= {word[WORD_W-BYTE_W-1:0], byte_data};
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (byte_cnt == BCNT_W'(3)) imem_wdata <= {word[WORD_W-BYTE_W-1:0], byte_data};
          end
        end
        WRITE: begin
          imem_addr <= imem_addr + ADDR_W'(1);
          word_cnt  <= word_cnt + BYTE_W'(1);
        end
        CHECK: begin
          if (accept) begin
            if (byte_data == csum) done  <= 1'b1;
            else                   error <= 1'b1;
          end
        end
        default: ;
      endcase
      // Discard any partially assembled word when returning to idle.
      if (state_next == IDLE) begin
        byte_cnt <= '0;
        word     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_enable;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                waits_q[$];
  logic [31:0]       pat [256];

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_enable(load_enable),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  // Record every memory write strobe mid-cycle.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a byte until it is accepted; waits = cycles spent with byte_ready low.
  task automatic send_byte(input logic [7:0] b, output int waits);
    logic rdy;
    bit   ok;
    waits = 0;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 16 && !ok; i++) begin
      rdy = byte_ready;
      step();
      if (rdy) ok = 1'b1;
      else     waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout byte=%h got ready=0 exp ready=1", b);
    end
  endtask

  // Send header, words pat[0..n-1] big-endian, then checksum XOR err.
  task automatic send_stream(input int n, input logic [7:0] err);
    logic [7:0]  cs;
    logic [7:0]  hb;
    logic [31:0] wd;
    int          w;
    waits_q.delete();
    hb = 8'(n - 1);
    cs = hb;
    send_byte(hb, w);
    waits_q.push_back(w);
    for (int i = 0; i < n; i++) begin
      wd = pat[i];
      for (int j = 3; j >= 0; j--) begin
        send_byte(wd[j*8 +: 8], w);
        cs = cs ^ wd[j*8 +: 8];
        waits_q.push_back(w);
      end
    end
    send_byte(cs ^ err, w);
    waits_q.push_back(w);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_enable = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    step(); step();
    checks++;
    if ({byte_ready, imem_we, cpu_hold, done, error, imem_addr, imem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b we=%b hold=%b done=%b err=%b addr=%h wdata=%h exp all 0",
               byte_ready, imem_we, cpu_hold, done, error, imem_addr, imem_wdata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    int w;
    wr_addr_q.delete(); wr_data_q.delete();
    load_enable = 1'b1;
    step();
    checks++;
    if ({cpu_hold, byte_ready} !== 2'b11) begin
      errors++; $display("FAIL single_header_state got hold/ready=%b%b exp 11", cpu_hold, byte_ready);
    end
    send_byte(8'h00, w); send_byte(8'h12, w); send_byte(8'h34, w);
    send_byte(8'h56, w); send_byte(8'h78, w);
    send_byte(8'h08, w);
    byte_valid = 1'b0;
    checks++;
    if (w !== 1) begin errors++; $display("FAIL single_csum_wait got %0d exp 1", w); end
    checks++;
    if ({done, error, cpu_hold, byte_ready} !== 4'b1000) begin
      errors++; $display("FAIL single_status got done/err/hold/ready=%b%b%b%b exp 1000", done, error, cpu_hold, byte_ready);
    end
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++; $display("FAIL single_write_count got %0d exp 1", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h12345678) begin
      errors++; $display("FAIL single_write got addr=%h data=%h exp addr=00 data=12345678", wr_addr_q[0], wr_data_q[0]);
    end
    load_enable = 1'b0;
    step();
    checks++;
    if ({done, cpu_hold} !== 2'b10) begin
      errors++; $display("FAIL single_idle got done/hold=%b%b exp 10", done, cpu_hold);
    end
  endtask

  task automatic test_back_to_back();
    int exp_w;
    wr_addr_q.delete(); wr_data_q.delete();
    pat[0] = 32'h11223344;
    pat[1] = 32'hA1B2C3D4;
    load_enable = 1'b1;
    step();
    send_stream(2, 8'h00);
    for (int k = 0; k < waits_q.size(); k++) begin
      exp_w = (k == 5 || k == 9) ? 1 : 0;
      checks++;
      if (waits_q[k] !== exp_w) begin
        errors++; $display("FAIL b2b_ready_gap byte %0d got wait=%0d exp %0d", k, waits_q[k], exp_w);
      end
    end
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++; $display("FAIL b2b_write_count got %0d exp 2", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h11223344 ||
                 wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL b2b_writes got %h:%h %h:%h exp 00:11223344 01:a1b2c3d4",
                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++; $display("FAIL b2b_done got done/err=%b%b exp 10", done, error);
    end
    load_enable = 1'b0;
    step();
  endtask

  task automatic test_bad_checksum();
    pat[0] = 32'h12345678;
    load_enable = 1'b1;
    step();
    send_stream(1, 8'h01);
    checks++;
    if ({error, done, cpu_hold, byte_ready} !== 4'b1010) begin
      errors++; $display("FAIL bad_csum_status got err/done/hold/ready=%b%b%b%b exp 1010", error, done, cpu_hold, byte_ready);
    end
    step(); step(); step();
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bad_csum_hold got %b exp 1", cpu_hold); end
    load_enable = 1'b0;
    step();
    checks++;
    if ({cpu_hold, error, done} !== 3'b010) begin
      errors++; $display("FAIL bad_csum_release got hold/err/done=%b%b%b exp 010", cpu_hold, error, done);
    end
  endtask

  task automatic test_abort();
    int w;
    wr_addr_q.delete(); wr_data_q.delete();
    load_enable = 1'b1;
    step();
    send_byte(8'h00, w); send_byte(8'hAA, w); send_byte(8'hBB, w);
    // Drop load_enable while a byte is offered and ready is high.
    byte_data = 8'hCC; byte_valid = 1'b1; load_enable = 1'b0;
    step();
    byte_valid = 1'b0;
    checks++;
    if ({cpu_hold, byte_ready, done, error} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle got hold/ready/done/err=%b%b%b%b exp 0000", cpu_hold, byte_ready, done, error);
    end
    step(); step();
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL abort_no_write got %0d writes exp 0", wr_addr_q.size()); end
    // Fresh load after the abort lands cleanly at address 0.
    pat[0] = 32'hDEADBEEF;
    load_enable = 1'b1;
    step();
    send_stream(1, 8'h00);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hDEADBEEF || done !== 1'b1) begin
      errors++; $display("FAIL abort_reload got writes=%0d done=%b exp 1 write 00:deadbeef done=1", wr_addr_q.size(), done);
    end
    load_enable = 1'b0;
    step();
  endtask

  task automatic test_full_memory();
    int bad;
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 256; i++) pat[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
    load_enable = 1'b1;
    step();
    send_stream(256, 8'h00);
    checks++;
    if (wr_addr_q.size() != 256) begin
      errors++; $display("FAIL full_write_count got %0d exp 256", wr_addr_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== pat[i]) begin
          errors++; bad++;
          if (bad < 4) $display("FAIL full_write %0d got %h:%h exp %h:%h", i, wr_addr_q[i], wr_data_q[i], 8'(i), pat[i]);
        end
      end
    end
    checks++;
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL full_addr_wrap got %h exp 00", imem_addr); end
    checks++;
    if ({done, error} !== 2'b10) begin errors++; $display("FAIL full_done got done/err=%b%b exp 10", done, error); end
    load_enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_data();
    int w;
    wr_addr_q.delete(); wr_data_q.delete();
    load_enable = 1'b1;
    step();
    send_byte(8'h00, w); send_byte(8'h55, w);
    byte_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({byte_ready, imem_we, cpu_hold, done, error, imem_addr, imem_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got ready=%b we=%b hold=%b done=%b err=%b addr=%h wdata=%h exp all 0",
               byte_ready, imem_we, cpu_hold, done, error, imem_addr, imem_wdata);
    end
    step();
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL mid_reset_no_write got %0d exp 0", wr_addr_q.size()); end
    pat[0] = 32'hCAFEF00D;
    send_stream(1, 8'h00);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hCAFEF00D || done !== 1'b1) begin
      errors++; $display("FAIL mid_reset_reload got writes=%0d done=%b exp 1 write 00:cafef00d done=1", wr_addr_q.size(), done);
    end
    load_enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_abort();
    test_full_memory();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
